// File: rtl/parc_core_reorder_buffer_if.sv
// Handshake and data bundle between the PARC pipeline and its reorder buffer.
// The master side is the pipeline (decode/writeback/bypass); the slave side is the ROB.
interface parc_core_reorder_buffer_if #(
    parameter int p_data_nbits = 32
);
    logic                    rob_alloc_req_val;
    logic                    rob_alloc_req_rdy;
    logic [4:0]              rob_alloc_req_preg;
    logic [3:0]              rob_alloc_resp_slot;
    logic                    rob_fill_val;
    logic [3:0]              rob_fill_slot;
    logic [p_data_nbits-1:0] rob_fill_data;
    logic                    rob_flush;
    logic                    rob_commit_wen;
    logic [3:0]              rob_commit_slot;
    logic [4:0]              rob_commit_rf_waddr;
    logic [p_data_nbits-1:0] rob_commit_rf_wdata;
    logic [3:0]              rob_byp0_slot;
    logic [p_data_nbits-1:0] rob_byp0_data;
    logic [3:0]              rob_byp1_slot;
    logic [p_data_nbits-1:0] rob_byp1_data;

    modport master (
        output rob_alloc_req_val, rob_alloc_req_preg,
        output rob_fill_val, rob_fill_slot, rob_fill_data,
        output rob_flush, rob_byp0_slot, rob_byp1_slot,
        input  rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_rf_wdata,
        input  rob_byp0_data, rob_byp1_data
    );

    modport slave (
        input  rob_alloc_req_val, rob_alloc_req_preg,
        input  rob_fill_val, rob_fill_slot, rob_fill_data,
        input  rob_flush, rob_byp0_slot, rob_byp1_slot,
        output rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_rf_wdata,
        output rob_byp0_data, rob_byp1_data
    );
endinterface

// File: rtl/parc_core_reorder_buffer.sv
// In-order commit reorder buffer for the PARC core. Slots are handed out at the
// tail, filled out of order by writeback, and retired one per cycle from the head.
// Entry data is deliberately left unreset; only the valid/pending bookkeeping is.
module parc_core_reorder_buffer #(
    parameter int p_entries    = 16,
    parameter int p_data_nbits = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    parc_core_reorder_buffer_if.slave    rob
);
    localparam logic [4:0] c_full = 5'(p_entries);

    logic [p_entries-1:0]    valid_q,   valid_d;
    logic [p_entries-1:0]    pending_q, pending_d;
    logic [3:0]              head_q,    head_d;
    logic [3:0]              tail_q,    tail_d;
    logic [4:0]              count_q,   count_d;
    logic [4:0]              preg_q [p_entries];
    logic [p_data_nbits-1:0] data_q [p_entries];

    logic alloc_rdy;
    logic alloc_fire;
    logic fill_fire;
    logic commit_fire;

    // Rdy looks only at registered count, so a full buffer stays blocked even
    // in the cycle its head retires.
    assign alloc_rdy   = (count_q != c_full) && !rob.rob_flush;
    assign alloc_fire  = rob.rob_alloc_req_val && alloc_rdy;
    assign fill_fire   = rob.rob_fill_val && valid_q[rob.rob_fill_slot] && !rob.rob_flush;
    assign commit_fire = valid_q[head_q] && !pending_q[head_q] && !rob.rob_flush;

    assign rob.rob_alloc_req_rdy   = alloc_rdy;
    assign rob.rob_alloc_resp_slot = tail_q;
    assign rob.rob_commit_wen      = commit_fire;
    assign rob.rob_commit_slot     = head_q;
    assign rob.rob_commit_rf_waddr = preg_q[head_q];
    assign rob.rob_commit_rf_wdata = data_q[head_q];
    assign rob.rob_byp0_data       = data_q[rob.rob_byp0_slot];
    assign rob.rob_byp1_data       = data_q[rob.rob_byp1_slot];

    // Next-state for the bookkeeping: flush wins; otherwise fill, commit and allocate
    // act together. Alloc at tail never collides with commit at head because the
    // tail slot is always invalid whenever an allocation can fire.
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (rob.rob_flush) begin
            valid_d   = '0;
            pending_d = '0;
            tail_d    = head_q;
            count_d   = '0;
        end else begin
            if (fill_fire) begin
                pending_d[rob.rob_fill_slot] = 1'b0;
            end
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 4'd1;
            end
            if (alloc_fire) begin
                valid_d[tail_q]   = 1'b1;
                pending_d[tail_q] = 1'b1;
                tail_d            = tail_q + 4'd1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Bookkeeping registers; reset drops every entry asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Entry payload storage: destination on allocate, result on fill.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            preg_q[tail_q] <= rob.rob_alloc_req_preg;
        end
        if (fill_fire) begin
            data_q[rob.rob_fill_slot] <= rob.rob_fill_data;
        end
    end
endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Directed bench for the PARC reorder buffer with a commit-order scoreboard.
module tb_parc_core_reorder_buffer;
    logic clk;
    logic reset;

    parc_core_reorder_buffer_if rob();

    parc_core_reorder_buffer dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] slot;
        logic [4:0] preg;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] m_data [16];
    logic [15:0] m_valid;
    logic [15:0] m_filled;
    logic [3:0]  exp_head;
    logic [3:0]  exp_tail;
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rob.rob_alloc_req_val  = 1'b0;
        rob.rob_alloc_req_preg = 5'd0;
        rob.rob_fill_val       = 1'b0;
        rob.rob_fill_slot      = 4'd0;
        rob.rob_fill_data      = 32'd0;
        rob.rob_flush          = 1'b0;
        rob.rob_byp0_slot      = 4'd0;
        rob.rob_byp1_slot      = 4'd0;
    endtask

    task automatic model_clear();
        sbq.delete();
        m_valid  = '0;
        m_filled = '0;
        exp_head = 4'd0;
        exp_tail = 4'd0;
    endtask

    // Sample this cycle's outputs against the model, then apply this cycle's stimulus to the model.
    task automatic look();
        logic exp_rdy;
        logic exp_wen;
        sb_t  e;
        #1;
        exp_rdy = (sbq.size() != 16) && !rob.rob_flush;
        exp_wen = (sbq.size() != 0) && !rob.rob_flush;
        if (sbq.size() != 0) exp_wen = exp_wen && m_filled[sbq[0].slot];
        chk("alloc_rdy", rob.rob_alloc_req_rdy, exp_rdy);
        chk("alloc_slot", rob.rob_alloc_resp_slot, exp_tail);
        chk("commit_wen", rob.rob_commit_wen, exp_wen);
        if (rob.rob_commit_wen && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("commit_slot", rob.rob_commit_slot, e.slot);
            chk("commit_waddr", rob.rob_commit_rf_waddr, e.preg);
            chk("commit_wdata", rob.rob_commit_rf_wdata, m_data[e.slot]);
            m_valid[e.slot] = 1'b0;
            exp_head = e.slot + 4'd1;
        end
        if (rob.rob_flush) begin
            sbq.delete();
            m_valid  = '0;
            m_filled = '0;
            exp_tail = exp_head;
        end else begin
            if (rob.rob_fill_val && m_valid[rob.rob_fill_slot]) begin
                m_data[rob.rob_fill_slot]   = rob.rob_fill_data;
                m_filled[rob.rob_fill_slot] = 1'b1;
            end
            if (rob.rob_alloc_req_val && exp_rdy) begin
                sbq.push_back('{slot: exp_tail, preg: rob.rob_alloc_req_preg});
                m_valid[exp_tail]  = 1'b1;
                m_filled[exp_tail] = 1'b0;
                exp_tail = exp_tail + 4'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"}, rob.rob_alloc_req_rdy, 1'b1);
        chk({tag, "_resp_slot"}, rob.rob_alloc_resp_slot, 4'd0);
        chk({tag, "_wen"}, rob.rob_commit_wen, 1'b0);
        chk({tag, "_commit_slot"}, rob.rob_commit_slot, 4'd0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk_reset_outs("rst");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] preg);
        idle();
        rob.rob_alloc_req_val  = 1'b1;
        rob.rob_alloc_req_preg = preg;
    endtask

    task automatic fill(input logic [3:0] slot, input logic [31:0] data);
        idle();
        rob.rob_fill_val  = 1'b1;
        rob.rob_fill_slot = slot;
        rob.rob_fill_data = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        model_clear();
        do_reset();

        // Single instruction: allocate, fill, commit.
        alloc(5'd5); look(); chk("t1_slot", rob.rob_alloc_resp_slot, 4'd0); step();
        fill(4'd0, 32'hDEADBEEF); look(); chk("t1_tail", rob.rob_alloc_resp_slot, 4'd1); step();
        idle(); look();
        chk("t2_wen", rob.rob_commit_wen, 1'b1);
        chk("t2_waddr", rob.rob_commit_rf_waddr, 5'd5);
        chk("t2_wdata", rob.rob_commit_rf_wdata, 32'hDEADBEEF);
        step();
        idle(); look();
        chk("t2_empty_wen", rob.rob_commit_wen, 1'b0);
        chk("t2_empty_head", rob.rob_commit_slot, 4'd1);
        step();

        // Out-of-order fills retire in program order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(5'(7 + i)); look(); step();
        end
        for (int i = 2; i >= 0; i--) begin
            fill(4'(i), 32'h100 + 32'(i)); look();
            chk("t3_no_commit", rob.rob_commit_wen, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle(); look();
            chk("t3_wen", rob.rob_commit_wen, 1'b1);
            chk("t3_order", rob.rob_commit_slot, 4'(i));
            step();
        end
        idle(); look(); step();

        // Full buffer, commit-cycle rdy, wrap of the tail.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i)); look(); step();
        end
        idle(); look();
        chk("t4_full_rdy", rob.rob_alloc_req_rdy, 1'b0);
        chk("t4_tail_wrap", rob.rob_alloc_resp_slot, 4'd0);
        chk("t4_head", rob.rob_commit_slot, 4'd0);
        step();
        fill(4'd0, 32'h000000A0); rob.rob_alloc_req_val = 1'b1; rob.rob_alloc_req_preg = 5'd20;
        look(); step();
        rob.rob_fill_val = 1'b0;
        look();
        chk("t4_commit_cycle_wen", rob.rob_commit_wen, 1'b1);
        chk("t4_commit_cycle_rdy", rob.rob_alloc_req_rdy, 1'b0);
        step();
        look();
        chk("t4_rdy_back", rob.rob_alloc_req_rdy, 1'b1);
        chk("t4_realloc_slot", rob.rob_alloc_resp_slot, 4'd0);
        step();

        // Bypass reads see stored data only, one cycle after the fill.
        fill(4'd3, 32'h00005555); look(); step();
        fill(4'd3, 32'h00001234); rob.rob_byp0_slot = 4'd3; rob.rob_byp1_slot = 4'd0;
        look();
        chk("t5_byp0_old", rob.rob_byp0_data, 32'h00005555);
        chk("t5_byp1", rob.rob_byp1_data, 32'h000000A0);
        step();
        idle(); rob.rob_byp0_slot = 4'd3;
        look();
        chk("t5_byp0_new", rob.rob_byp0_data, 32'h00001234);
        step();

        // Flush with head=2, tail=6 and a committable head.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(5'(10 + i)); look(); step();
        end
        fill(4'd0, 32'h00000011); look(); step();
        fill(4'd1, 32'h00000022); look(); step();
        fill(4'd2, 32'h00000033); look(); step();
        fill(4'd3, 32'h00000044); rob.rob_flush = 1'b1;
        look();
        chk("t6_flush_wen", rob.rob_commit_wen, 1'b0);
        chk("t6_flush_rdy", rob.rob_alloc_req_rdy, 1'b0);
        step();
        idle(); look();
        chk("t6_post_wen", rob.rob_commit_wen, 1'b0);
        chk("t6_post_head", rob.rob_commit_slot, 4'd2);
        chk("t6_post_tail", rob.rob_alloc_resp_slot, 4'd2);
        step();
        alloc(5'd12); look(); chk("t6_next_slot", rob.rob_alloc_resp_slot, 4'd2); step();
        alloc(5'd13); rob.rob_fill_val = 1'b1; rob.rob_fill_slot = 4'd2; rob.rob_fill_data = 32'h00000222;
        look(); step();
        idle(); look();
        chk("t6_commit_after_flush", rob.rob_commit_wen, 1'b1);
        step();
        idle(); look();
        chk("t6_slot3_pending", rob.rob_commit_wen, 1'b0);
        step();

        // Asynchronous reset in the middle of a pending commit.
        fill(4'd3, 32'h00000333); look(); step();
        idle();
        reset = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        alloc(5'd0); look(); step();
        fill(4'd0, 32'h0000CAFE); look(); step();
        idle(); look();
        chk("t7_preg0_commit", rob.rob_commit_wen, 1'b1);
        step();
        idle(); look(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
